uart_encoder: RTL

Transmit-side counterpart of the UART instruction-word decoder. Accepts 16-bit words through a valid/ready handshake and buffers them in a small FIFO. Serializes each word low byte first into a byte-wide valid/ready stream feeding the UART transmitter. Sits between the core's readback/debug path and the UART TX, and keeps a running byte address identical in meaning to the decoder's.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_word_fifo.sv | 75 +++++++
 rtl/uart_encoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART instruction-word encoder and decoder:
//   byte/word widths, the encoder FSM state type, and the byte-address
//   increment applied per completed word.
//   Optional feature macro: UART_ENCODER_CHECKSUM_EN adds the S_CHECK state.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int UART_WORD_W = 16;

    // One 16-bit word spans two byte addresses on both sides of the link.
    localparam logic [31:0] UART_ADDR_INC = 32'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE0 = 2'd1,
        S_BYTE1 = 2'd2
`ifdef UART_ENCODER_CHECKSUM_EN
        ,
        S_CHECK = 2'd3
`endif
    } enc_state_e;

endpackage

// File: rtl/uart_word_fifo.sv
// uart_word_fifo
//   Synchronous word FIFO with registered occupancy count.
//   Ports:
//     clk, reset_n    clock, synchronous active-low reset
//     push, push_data write request / data (ignored when full)
//     pop             read request (ignored when empty); advances head
//     head_data       word at the head of the FIFO
//     count           words currently stored (0..FIFO_DEPTH)
//     full, empty     derived from the registered count
module uart_word_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = UART_WORD_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Full refuses a push even when a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_encoder.sv
// uart_encoder
//   Buffers 16-bit instruction words and serialises each one, low byte
//   first, onto a byte-wide valid/ready stream for the UART transmitter.
//   Tracks the byte address of the next word to be sent.
//   Optional feature macro: UART_ENCODER_CHECKSUM_EN appends a third byte
//   (low ^ high) to every word; word completion then happens on that byte.
//   Ports:
//     clk, reset_n      clock, synchronous active-low reset
//     word_valid        producer offers instruction_word
//     instruction_word  word to send
//     word_ready        FIFO can accept a word
//     io_tx_data        byte to the UART TX
//     io_tx_valid       io_tx_data valid
//     io_tx_ready       UART TX accepts the byte this cycle
//     byte_address      address of the next word to be sent (+2 per word)
//     fifo_count        words currently buffered
//     busy              FIFO non-empty or a word in flight
//
//   state   | meaning
//   S_IDLE  | nothing in flight; pops the FIFO head when available
//   S_BYTE0 | presenting hold[7:0]
//   S_BYTE1 | presenting hold[15:8]
//   S_CHECK | presenting hold[7:0] ^ hold[15:8] (checksum build only)
module uart_encoder
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         word_valid,
    input  logic [UART_WORD_W-1:0]       instruction_word,
    output logic                         word_ready,
    output logic [UART_BYTE_W-1:0]       io_tx_data,
    output logic                         io_tx_valid,
    input  logic                         io_tx_ready,
    output logic [31:0]                  byte_address,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy
);

    enc_state_e               r_state;
    enc_state_e               w_next_state;
    logic [UART_WORD_W-1:0]   r_hold;
    logic [31:0]              r_byte_address;

    logic                     w_pop;
    logic                     w_word_done;
    logic [UART_WORD_W-1:0]   w_head_data;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                     w_full;
    logic                     w_empty;

    uart_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (UART_WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (word_valid),
        .push_data (instruction_word),
        .pop       (w_pop),
        .head_data (w_head_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_hold         <= '0;
            r_byte_address <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_hold <= w_head_data;
            end
            if (w_word_done) begin
                r_byte_address <= r_byte_address + UART_ADDR_INC;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_word_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_BYTE0;
                end
            end
            S_BYTE0: begin
                if (io_tx_ready) begin
                    w_next_state = S_BYTE1;
                end
            end
            S_BYTE1: begin
                if (io_tx_ready) begin
`ifdef UART_ENCODER_CHECKSUM_EN
                    w_next_state = S_CHECK;
`else
                    w_word_done  = 1'b1;
`endif
                end
            end
`ifdef UART_ENCODER_CHECKSUM_EN
            S_CHECK: begin
                if (io_tx_ready) begin
                    w_word_done = 1'b1;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Chain straight into the next buffered word so the stream has no bubble.
        if (w_word_done) begin
            if (!w_empty) begin
                w_pop        = 1'b1;
                w_next_state = S_BYTE0;
            end else begin
                w_next_state = S_IDLE;
            end
        end
    end

    // Outputs depend only on registered state, holding register and count.
    always_comb begin
        io_tx_data = '0;
        case (r_state)
            S_BYTE0: io_tx_data = r_hold[7:0];
            S_BYTE1: io_tx_data = r_hold[15:8];
`ifdef UART_ENCODER_CHECKSUM_EN
            S_CHECK: io_tx_data = r_hold[7:0] ^ r_hold[15:8];
`endif
            default: io_tx_data = '0;
        endcase
    end

    assign io_tx_valid  = (r_state != S_IDLE);
    assign word_ready   = !w_full;
    assign fifo_count   = w_count;
    assign byte_address = r_byte_address;
    assign busy         = (w_count != '0) || (r_state != S_IDLE);

endmodule
